// File: rtl/coreriscv_axi4_client_finish_unit.sv
// ---------------------------------------------------------------------------
// coreriscv_axi4_client_finish_unit
//
// Client-side grant receiver for the TileLink network. Grant beats coming out
// of the manager network port pass straight through to the client with no
// latency. Every grant that needs acknowledgement (non-builtin types) pushes
// a finish message into a small FIFO on its last beat. The FIFO drains to the
// manager network port independently of the grant stream. A beat counter
// follows multibeat grants and flags out-of-sequence beat indices.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   io_net_grant_*             grant channel from the network (valid/ready)
//   io_client_grant_*          grant payload copy towards the client
//   io_net_finish_*            finish message towards the network
//   io_beat_err                sticky beat-sequence error
//   io_busy                    multibeat in progress or finishes pending
//
// Parameters
//   FINISH_DEPTH               finish FIFO entries (power of two, >= 2)
// ---------------------------------------------------------------------------
module coreriscv_axi4_client_finish_unit #(
   parameter int FINISH_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        io_net_grant_valid,
   output logic        io_net_grant_ready,
   input  logic [1:0]  io_net_grant_bits_header_src,
   input  logic [1:0]  io_net_grant_bits_header_dst,
   input  logic [2:0]  io_net_grant_bits_payload_addr_beat,
   input  logic        io_net_grant_bits_payload_client_xact_id,
   input  logic [1:0]  io_net_grant_bits_payload_manager_xact_id,
   input  logic        io_net_grant_bits_payload_is_builtin_type,
   input  logic [3:0]  io_net_grant_bits_payload_g_type,
   input  logic [63:0] io_net_grant_bits_payload_data,

   output logic        io_client_grant_valid,
   input  logic        io_client_grant_ready,
   output logic [2:0]  io_client_grant_bits_addr_beat,
   output logic        io_client_grant_bits_client_xact_id,
   output logic [1:0]  io_client_grant_bits_manager_xact_id,
   output logic        io_client_grant_bits_is_builtin_type,
   output logic [3:0]  io_client_grant_bits_g_type,
   output logic [63:0] io_client_grant_bits_data,

   output logic        io_net_finish_valid,
   input  logic        io_net_finish_ready,
   output logic [1:0]  io_net_finish_bits_header_src,
   output logic [1:0]  io_net_finish_bits_header_dst,
   output logic [1:0]  io_net_finish_bits_payload_manager_xact_id,

   output logic        io_beat_err,
   output logic        io_busy
);

   localparam int PTR_W = $clog2(FINISH_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [2:0]       beat_cnt;
   logic             beat_err_q;

   // Each entry holds {src, dst, manager_xact_id} of one finish message.
   logic [5:0]       fifo_mem [FINISH_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_cnt;

   logic multibeat;
   logic needs_finish;
   logic last_beat;
   logic fifo_full;
   logic fifo_empty;
   logic stall;
   logic xfer;
   logic enq;
   logic deq;

   // Grant classification: builtin type 5 and custom types 0/1 carry 8 beats.
   assign multibeat    = io_net_grant_bits_payload_is_builtin_type
                         ? (io_net_grant_bits_payload_g_type == 4'h5)
                         : (io_net_grant_bits_payload_g_type <= 4'h1);
   assign needs_finish = !io_net_grant_bits_payload_is_builtin_type;
   assign last_beat    = !multibeat | (beat_cnt == 3'd7);

   assign fifo_full  = (fifo_cnt == CNT_W'(FINISH_DEPTH));
   assign fifo_empty = (fifo_cnt == '0);

   // A beat that would need a finish slot while the FIFO is full is held off
   // entirely: the client must not see a beat the network has not released.
   // Occupancy is the current value, so a same-cycle dequeue does not help.
   assign stall = needs_finish & last_beat & fifo_full;

   assign io_client_grant_valid = io_net_grant_valid & !stall;
   assign io_net_grant_ready    = io_client_grant_ready & !stall;

   assign io_client_grant_bits_addr_beat       = io_net_grant_bits_payload_addr_beat;
   assign io_client_grant_bits_client_xact_id  = io_net_grant_bits_payload_client_xact_id;
   assign io_client_grant_bits_manager_xact_id = io_net_grant_bits_payload_manager_xact_id;
   assign io_client_grant_bits_is_builtin_type = io_net_grant_bits_payload_is_builtin_type;
   assign io_client_grant_bits_g_type          = io_net_grant_bits_payload_g_type;
   assign io_client_grant_bits_data            = io_net_grant_bits_payload_data;

   assign xfer = io_net_grant_valid & io_net_grant_ready;
   assign enq  = xfer & needs_finish & last_beat;
   assign deq  = !fifo_empty & io_net_finish_ready;

   assign io_net_finish_valid                       = !fifo_empty;
   assign io_net_finish_bits_header_src             = fifo_mem[rd_ptr][5:4];
   assign io_net_finish_bits_header_dst             = fifo_mem[rd_ptr][3:2];
   assign io_net_finish_bits_payload_manager_xact_id = fifo_mem[rd_ptr][1:0];

   assign io_beat_err = beat_err_q;
   assign io_busy     = (beat_cnt != 3'd0) | !fifo_empty;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(FINISH_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   // Beat tracking: the counter, not addr_beat, drives sequencing, so a bad
   // index is flagged but never derails the burst.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt   <= 3'd0;
         beat_err_q <= 1'b0;
      end else if (xfer && multibeat) begin
         beat_cnt <= beat_cnt + 3'd1;
         if (io_net_grant_bits_payload_addr_beat != beat_cnt) begin
            beat_err_q <= 1'b1;
         end
      end
   end

   // FIFO pointers and occupancy. A simultaneous enqueue and dequeue leaves
   // the occupancy unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (deq) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({enq, deq})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Finish payload storage: the finish is addressed back to the manager, so
   // the grant's source and destination swap roles.
   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_mem[wr_ptr] <= {io_net_grant_bits_header_dst,
                              io_net_grant_bits_header_src,
                              io_net_grant_bits_payload_manager_xact_id};
      end
   end

endmodule

// File: tb/tb_coreriscv_axi4_client_finish_unit.sv
// ---------------------------------------------------------------------------
// tb_coreriscv_axi4_client_finish_unit
//
// Directed bench for the client finish unit. Stimulus pushes the expected
// client beat and finish message into queues; a monitor pops and compares on
// every client and finish handshake. Directed checks cover flow control,
// status outputs and reset behaviour.
// ---------------------------------------------------------------------------
module tb_coreriscv_axi4_client_finish_unit;

   logic        clk;
   logic        reset;
   logic        io_net_grant_valid;
   logic        io_net_grant_ready;
   logic [1:0]  io_net_grant_bits_header_src;
   logic [1:0]  io_net_grant_bits_header_dst;
   logic [2:0]  io_net_grant_bits_payload_addr_beat;
   logic        io_net_grant_bits_payload_client_xact_id;
   logic [1:0]  io_net_grant_bits_payload_manager_xact_id;
   logic        io_net_grant_bits_payload_is_builtin_type;
   logic [3:0]  io_net_grant_bits_payload_g_type;
   logic [63:0] io_net_grant_bits_payload_data;
   logic        io_client_grant_valid;
   logic        io_client_grant_ready;
   logic [2:0]  io_client_grant_bits_addr_beat;
   logic        io_client_grant_bits_client_xact_id;
   logic [1:0]  io_client_grant_bits_manager_xact_id;
   logic        io_client_grant_bits_is_builtin_type;
   logic [3:0]  io_client_grant_bits_g_type;
   logic [63:0] io_client_grant_bits_data;
   logic        io_net_finish_valid;
   logic        io_net_finish_ready;
   logic [1:0]  io_net_finish_bits_header_src;
   logic [1:0]  io_net_finish_bits_header_dst;
   logic [1:0]  io_net_finish_bits_payload_manager_xact_id;
   logic        io_beat_err;
   logic        io_busy;

   int checks = 0;
   int errors = 0;

   logic [74:0] client_q [$];
   logic [5:0]  finish_q [$];

   coreriscv_axi4_client_finish_unit #(.FINISH_DEPTH(2)) dut (
      .clk                                        (clk),
      .reset                                      (reset),
      .io_net_grant_valid                         (io_net_grant_valid),
      .io_net_grant_ready                         (io_net_grant_ready),
      .io_net_grant_bits_header_src               (io_net_grant_bits_header_src),
      .io_net_grant_bits_header_dst               (io_net_grant_bits_header_dst),
      .io_net_grant_bits_payload_addr_beat        (io_net_grant_bits_payload_addr_beat),
      .io_net_grant_bits_payload_client_xact_id   (io_net_grant_bits_payload_client_xact_id),
      .io_net_grant_bits_payload_manager_xact_id  (io_net_grant_bits_payload_manager_xact_id),
      .io_net_grant_bits_payload_is_builtin_type  (io_net_grant_bits_payload_is_builtin_type),
      .io_net_grant_bits_payload_g_type           (io_net_grant_bits_payload_g_type),
      .io_net_grant_bits_payload_data             (io_net_grant_bits_payload_data),
      .io_client_grant_valid                      (io_client_grant_valid),
      .io_client_grant_ready                      (io_client_grant_ready),
      .io_client_grant_bits_addr_beat             (io_client_grant_bits_addr_beat),
      .io_client_grant_bits_client_xact_id        (io_client_grant_bits_client_xact_id),
      .io_client_grant_bits_manager_xact_id       (io_client_grant_bits_manager_xact_id),
      .io_client_grant_bits_is_builtin_type       (io_client_grant_bits_is_builtin_type),
      .io_client_grant_bits_g_type                (io_client_grant_bits_g_type),
      .io_client_grant_bits_data                  (io_client_grant_bits_data),
      .io_net_finish_valid                        (io_net_finish_valid),
      .io_net_finish_ready                        (io_net_finish_ready),
      .io_net_finish_bits_header_src              (io_net_finish_bits_header_src),
      .io_net_finish_bits_header_dst              (io_net_finish_bits_header_dst),
      .io_net_finish_bits_payload_manager_xact_id (io_net_finish_bits_payload_manager_xact_id),
      .io_beat_err                                (io_beat_err),
      .io_busy                                    (io_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: compares every handshake against the queued
   // expectations, sampling on the falling edge away from the active edge.
   always @(negedge clk) begin
      if (reset && io_client_grant_valid && io_client_grant_ready) begin
         if (client_q.size() == 0) begin
            check_output("client_unexpected", 80'd1, 80'd0);
         end else begin
            check_output("client_beat",
                         {5'd0, io_client_grant_bits_addr_beat, io_client_grant_bits_client_xact_id,
                          io_client_grant_bits_manager_xact_id, io_client_grant_bits_is_builtin_type,
                          io_client_grant_bits_g_type, io_client_grant_bits_data},
                         {5'd0, client_q.pop_front()});
         end
      end
      if (reset && io_net_finish_valid && io_net_finish_ready) begin
         if (finish_q.size() == 0) begin
            check_output("finish_unexpected", 80'd1, 80'd0);
         end else begin
            check_output("finish_msg",
                         {74'd0, io_net_finish_bits_header_src, io_net_finish_bits_header_dst,
                          io_net_finish_bits_payload_manager_xact_id},
                         {74'd0, finish_q.pop_front()});
         end
      end
   end

   // Presents one grant beat and records what the client and (optionally)
   // the finish channel are expected to see for it.
   task automatic apply_stimulus(input logic [1:0] src, input logic [1:0] dst, input logic [2:0] beat,
                                 input logic cx, input logic [1:0] mx, input logic bi,
                                 input logic [3:0] gt, input logic [63:0] data, input bit fin);
      io_net_grant_bits_header_src              = src;
      io_net_grant_bits_header_dst              = dst;
      io_net_grant_bits_payload_addr_beat       = beat;
      io_net_grant_bits_payload_client_xact_id  = cx;
      io_net_grant_bits_payload_manager_xact_id = mx;
      io_net_grant_bits_payload_is_builtin_type = bi;
      io_net_grant_bits_payload_g_type          = gt;
      io_net_grant_bits_payload_data            = data;
      io_net_grant_valid                        = 1'b1;
      client_q.push_back({beat, cx, mx, bi, gt, data});
      if (fin) finish_q.push_back({dst, src, mx});
   endtask

   task automatic wait_xfer(input string name);
      int n = 0;
      @(negedge clk);
      while (!(io_net_grant_valid && io_net_grant_ready) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout actual=no_transfer expected=transfer", name);
      end
      @(posedge clk);
      #1;
      io_net_grant_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [1:0] src, input logic [1:0] dst, input logic [2:0] beat,
                            input logic [1:0] mx, input logic bi, input logic [3:0] gt, input bit fin);
      apply_stimulus(src, dst, beat, beat[0], mx, bi, gt, {32'hC0DE_0000, 16'(gt), 13'd0, beat}, fin);
      wait_xfer("grant_xfer");
   endtask

   task automatic drain_finish();
      int n = 0;
      io_net_finish_ready = 1'b1;
      while (io_net_finish_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain timeout actual=valid expected=empty");
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset                 = 1'b0;
      io_client_grant_ready = 1'b1;
      io_net_finish_ready   = 1'b1;
      apply_stimulus(2'h0, 2'h1, 3'h0, 1'b0, 2'h0, 1'b1, 4'h3, 64'h1234, 1'b0);
      void'(client_q.pop_back());
      #2;
      check_output("rst_beat_err", 80'(io_beat_err), 80'd0);
      check_output("rst_finish_valid", 80'(io_net_finish_valid), 80'd0);
      check_output("rst_busy", 80'(io_busy), 80'd0);
      check_output("rst_client_valid", 80'(io_client_grant_valid), 80'd1);
      check_output("rst_grant_ready", 80'(io_net_grant_ready), 80'd1);
      io_net_grant_valid = 1'b0;
      @(posedge clk);
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single-beat builtin grant");
      send_beat(2'h0, 2'h1, 3'h0, 2'h1, 1'b1, 4'h3, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_output("t1_finish_valid", 80'(io_net_finish_valid), 80'd0);
      check_output("t1_busy", 80'(io_busy), 80'd0);

      $display("[TB] 8-beat non-builtin grant");
      for (int i = 0; i < 8; i++) begin
         if (i == 7) check_output("t2_no_early_finish", 80'(io_net_finish_valid), 80'd0);
         send_beat(2'h0, 2'h1, 3'(i), 2'h2, 1'b0, 4'h0, i == 7);
         if (i == 3) check_output("t2_busy_mid", 80'(io_busy), 80'd1);
      end
      check_output("t2_finish_valid", 80'(io_net_finish_valid), 80'd1);
      check_output("t2_finish_bits",
                   {74'd0, io_net_finish_bits_header_src, io_net_finish_bits_header_dst,
                    io_net_finish_bits_payload_manager_xact_id}, {74'd0, 2'h1, 2'h0, 2'h2});
      @(posedge clk);
      #1;
      check_output("t2_finish_gone", 80'(io_net_finish_valid), 80'd0);
      check_output("t2_busy_end", 80'(io_busy), 80'd0);

      $display("[TB] finish FIFO full stall");
      io_net_finish_ready = 1'b0;
      send_beat(2'h0, 2'h1, 3'h0, 2'h0, 1'b0, 4'h3, 1'b1);
      send_beat(2'h0, 2'h1, 3'h0, 2'h1, 1'b0, 4'h3, 1'b1);
      check_output("t3_finish_valid", 80'(io_net_finish_valid), 80'd1);
      apply_stimulus(2'h0, 2'h1, 3'h0, 1'b1, 2'h3, 1'b0, 4'h3, 64'hFEED, 1'b1);
      @(negedge clk);
      check_output("t3_stall_ready", 80'(io_net_grant_ready), 80'd0);
      check_output("t3_stall_cvalid", 80'(io_client_grant_valid), 80'd0);
      @(posedge clk);
      #1;
      io_net_finish_ready = 1'b1;
      @(negedge clk);
      check_output("t3_no_flow_through", 80'(io_net_grant_ready), 80'd0);
      @(posedge clk);
      #1;
      io_net_finish_ready = 1'b0;
      wait_xfer("t3_third_grant");
      drain_finish();
      check_output("t3_busy_end", 80'(io_busy), 80'd0);

      $display("[TB] beat index error");
      for (int i = 0; i < 8; i++) begin
         send_beat(2'h1, 2'h2, (i == 3) ? 3'h5 : 3'(i), 2'h3, 1'b0, 4'h1, i == 7);
         if (i == 2) check_output("t4_err_before", 80'(io_beat_err), 80'd0);
         if (i == 3) check_output("t4_err_set", 80'(io_beat_err), 80'd1);
      end
      check_output("t4_err_sticky", 80'(io_beat_err), 80'd1);
      check_output("t4_finish_valid", 80'(io_net_finish_valid), 80'd1);
      drain_finish();

      $display("[TB] client backpressure mid-burst");
      for (int i = 0; i < 3; i++) send_beat(2'h2, 2'h3, 3'(i), 2'h1, 1'b0, 4'h0, 1'b0);
      io_client_grant_ready = 1'b0;
      apply_stimulus(2'h2, 2'h3, 3'h3, 1'b1, 2'h1, 1'b0, 4'h0, 64'hBEEF_0003, 1'b0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_output("t5_grant_ready", 80'(io_net_grant_ready), 80'd0);
         check_output("t5_busy", 80'(io_busy), 80'd1);
      end
      @(posedge clk);
      #1;
      io_client_grant_ready = 1'b1;
      wait_xfer("t5_resume");
      for (int i = 4; i < 8; i++) send_beat(2'h2, 2'h3, 3'(i), 2'h1, 1'b0, 4'h0, i == 7);
      check_output("t5_finish_valid", 80'(io_net_finish_valid), 80'd1);
      drain_finish();
      check_output("t5_busy_end", 80'(io_busy), 80'd0);

      $display("[TB] reset mid-burst");
      io_net_finish_ready = 1'b0;
      send_beat(2'h1, 2'h0, 3'h0, 2'h2, 1'b0, 4'h3, 1'b0);
      for (int i = 0; i < 5; i++) send_beat(2'h1, 2'h0, 3'(i), 2'h2, 1'b0, 4'h0, 1'b0);
      check_output("t6_pending", 80'(io_net_finish_valid), 80'd1);
      #2;
      reset = 1'b0;
      #1;
      check_output("t6_rst_finish_valid", 80'(io_net_finish_valid), 80'd0);
      check_output("t6_rst_busy", 80'(io_busy), 80'd0);
      check_output("t6_rst_beat_err", 80'(io_beat_err), 80'd0);
      @(posedge clk);
      #3;
      reset = 1'b1;
      io_net_finish_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) send_beat(2'h3, 2'h0, 3'(i), 2'h0, 1'b0, 4'h0, i == 7);
      check_output("t6_finish_valid", 80'(io_net_finish_valid), 80'd1);
      check_output("t6_beat_err", 80'(io_beat_err), 80'd0);
      drain_finish();
      check_output("t6_busy_end", 80'(io_busy), 80'd0);

      repeat (2) @(posedge clk);
      check_output("client_q_empty", 80'(client_q.size()), 80'd0);
      check_output("finish_q_empty", 80'(finish_q.size()), 80'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
